// File: rtl/freq_disp_pkg.sv
// Shared types and defaults for the frequency display path (binary-to-BCD conversion).
package freq_disp_pkg;

    localparam int BIN_W_DEF  = 32;
    localparam int DIGITS_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj
    import freq_disp_pkg::*;
(
    input  bcd_digit_t dig_i,
    output bcd_digit_t dig_o
);

    // Add 3 so the following left shift carries into the next decimal digit
    always_comb begin
        if (dig_i >= 4'd5) begin
            dig_o = dig_i + 4'd3;
        end else begin
            dig_o = dig_i;
        end
    end

endmodule

// File: rtl/freq_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, start/busy/done handshake.
// Optional leading-zero blank mask enabled by defining FREQ_BCD_LZ_BLANK_EN.
module freq_bcd_conv
    import freq_disp_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk_100kHz,
    input  logic                  rst_,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int ACC_W = 4 * DIGITS;

    state_e             state_q;
    logic [BIN_W-1:0]   sh_q;
    logic [BIN_W-1:0]   sh_d;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [ACC_W-1:0]   adj_s;
    logic [ACC_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_i (acc_q[4*g +: 4]),
            .dig_o (adj_s[4*g +: 4])
        );
    end

    // Corrected accumulator and shift register move left as one long register
    always_comb begin
        {acc_d, sh_d} = {adj_s, sh_q} << 1;
    end

    // Conversion FSM; outputs are registered and only updated in DONE
    always_ff @(posedge clk_100kHz) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sh_q    <= bin_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sh_q  <= sh_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_q   <= acc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FREQ_BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] blank_d;
    logic [DIGITS-1:0] blank_q;
    logic              zero_run_s;

    // A digit is blanked when it and every digit above it are zero; units never blank
    always_comb begin
        blank_d    = '0;
        zero_run_s = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run_s = zero_run_s & (acc_q[4*i +: 4] == 4'd0);
            blank_d[i] = zero_run_s;
        end
    end

    // Blank mask loads together with bcd_out
    always_ff @(posedge clk_100kHz) begin
        if (!rst_) begin
            blank_q <= '0;
        end else if (state_q == ST_DONE) begin
            blank_q <= blank_d;
        end else begin
            blank_q <= blank_q;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_freq_bcd_conv.sv
// Directed self-checking bench for freq_bcd_conv with hand-computed BCD and blank values.
`timescale 1us/1ns
module tb_freq_bcd_conv;

    logic        clk_100kHz;
    logic        rst_;
    logic        start;
    logic [31:0] bin_in;
    logic        busy;
    logic        done;
    logic [39:0] bcd_out;
    logic [9:0]  blank;

    int n_checks;
    int n_errors;
    int cyc;
    int done_cnt;
    int start_cyc;
    int done_cyc;
    int busy_cnt;
    int done_cyc_a;

    freq_bcd_conv dut (
        .clk_100kHz (clk_100kHz),
        .rst_       (rst_),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .bcd_out    (bcd_out),
        .blank      (blank)
    );

    initial clk_100kHz = 1'b0;
    always #5 clk_100kHz = ~clk_100kHz;

    always @(posedge clk_100kHz) cyc <= cyc + 1;
    always @(negedge clk_100kHz) if (done) done_cnt <= done_cnt + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] exp_blank(input logic [9:0] mask);
`ifdef FREQ_BCD_LZ_BLANK_EN
        return mask;
`else
        return mask & 10'd0;
`endif
    endfunction

    // Called at a negedge; start is seen by the next rising edge
    task automatic start_conv(input logic [31:0] v);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk_100kHz);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done();
        int t;
        t        = 0;
        busy_cnt = 0;
        while (!done && t < 200) begin
            if (busy) busy_cnt++;
            @(negedge clk_100kHz);
            t++;
        end
        if (!done) begin
            check_val("done_timeout", 64'd0, 64'd1);
        end
        done_cyc = cyc;
    endtask

    task automatic run_conv(input string tag, input logic [31:0] v,
                            input logic [39:0] exp_bcd, input logic [9:0] mask);
        int d0;
        @(negedge clk_100kHz);
        d0 = done_cnt;
        start_conv(v);
        wait_done();
        check_val({tag, "_latency"}, 64'(done_cyc - start_cyc), 64'd33);
        check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check_val({tag, "_bcd"}, {24'd0, bcd_out}, {24'd0, exp_bcd});
        check_val({tag, "_blank"}, {54'd0, blank}, {54'd0, exp_blank(mask)});
        @(negedge clk_100kHz);
        check_val({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check_val({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        check_val({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        check_val({tag, "_bcd_hold"}, {24'd0, bcd_out}, {24'd0, exp_bcd});
    endtask

    initial begin
        int d0;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        done_cnt = 0;
        rst_     = 1'b0;
        start    = 1'b0;
        bin_in   = 32'd0;
        repeat (3) @(negedge clk_100kHz);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_bcd", {24'd0, bcd_out}, 64'd0);
        check_val("rst_blank", {54'd0, blank}, 64'd0);
        rst_ = 1'b1;

        run_conv("zero", 32'd0, 40'h00_0000_0000, 10'b1111111110);
        run_conv("v1234", 32'd1234, 40'h00_0000_1234, 10'b1111110000);
        run_conv("vmax", 32'hFFFF_FFFF, 40'h42_9496_7295, 10'b0000000000);

        // Second start mid-conversion with a new bin_in must be ignored
        @(negedge clk_100kHz);
        d0 = done_cnt;
        start_conv(32'd5678);
        repeat (9) @(negedge clk_100kHz);
        start  = 1'b1;
        bin_in = 32'd99;
        @(negedge clk_100kHz);
        start = 1'b0;
        wait_done();
        check_val("ign_latency", 64'(done_cyc - start_cyc), 64'd33);
        check_val("ign_bcd", {24'd0, bcd_out}, 64'h00_0000_5678);
        check_val("ign_blank", {54'd0, blank}, {54'd0, exp_blank(10'b1111110000)});
        repeat (40) @(negedge clk_100kHz);
        check_val("ign_done_count", 64'(done_cnt - d0), 64'd1);
        check_val("ign_idle_busy", {63'd0, busy}, 64'd0);

        // Reset in the middle of a conversion aborts it
        d0 = done_cnt;
        start_conv(32'd1000);
        repeat (14) @(negedge clk_100kHz);
        rst_ = 1'b0;
        @(negedge clk_100kHz);
        check_val("abort_busy", {63'd0, busy}, 64'd0);
        check_val("abort_bcd", {24'd0, bcd_out}, 64'd0);
        check_val("abort_blank", {54'd0, blank}, 64'd0);
        rst_ = 1'b1;
        repeat (40) @(negedge clk_100kHz);
        check_val("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check_val("abort_bcd_hold", {24'd0, bcd_out}, 64'd0);
        run_conv("v42", 32'd42, 40'h00_0000_0042, 10'b1111111100);

        // Back-to-back: second start on the edge right after done
        @(negedge clk_100kHz);
        d0 = done_cnt;
        start_conv(32'd100000);
        wait_done();
        done_cyc_a = done_cyc;
        check_val("b2b_a_bcd", {24'd0, bcd_out}, 64'h00_0010_0000);
        check_val("b2b_a_blank", {54'd0, blank}, {54'd0, exp_blank(10'b1111000000)});
        start_conv(32'd7);
        check_val("b2b_a_pulse", {63'd0, done}, 64'd0);
        check_val("b2b_b_busy", {63'd0, busy}, 64'd1);
        wait_done();
        check_val("b2b_b_bcd", {24'd0, bcd_out}, 64'h00_0000_0007);
        check_val("b2b_b_blank", {54'd0, blank}, {54'd0, exp_blank(10'b1111111110)});
        check_val("b2b_spacing", 64'(done_cyc - done_cyc_a), 64'd34);
        @(negedge clk_100kHz);
        check_val("b2b_done_count", 64'(done_cnt - d0), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
